// File: rtl/ifu_inst_fetch.sv
// ifu_inst_fetch: instruction-fetch request stage between the PC counter and IF/ID.
// Issues one read per new PC, holds the returned instruction until IF/ID takes
// it, and discards in-flight data on a branch flush without breaking the
// memory handshake.
// Optional feature macro: IFU_ACCESS_FAULT_EN (non-OKAY read responses raise
// IFU_o_fault and substitute NOP_INST).
module ifu_inst_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFU_o_pc,
  input  logic        pc_change,
  input  logic        BRANCH_flushIF,
  input  logic        FORWARD_stallID,
  output logic        IFU_arvalid,
  output logic [31:0] IFU_araddr,
  input  logic        IFU_arready,
  input  logic        IFU_rvalid,
  input  logic [31:0] IFU_rdata,
  input  logic [1:0]  IFU_rresp,
  output logic        IFU_rready,
  output logic [31:0] IFU_o_inst,
  output logic [31:0] IFU_o_inst_pc,
  output logic        IFU_o_valid,
  output logic        IFU_o_fault,
  output logic        IFU_o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        discard_r;
  logic        discard_s;
  logic        launch_s;
  logic        take_s;
  logic        release_s;
  logic        busy_s;
  logic        arvalid_r;
  logic        rready_r;
  logic [31:0] req_pc_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic        valid_r;
  logic        fault_r;

`ifndef IFU_ACCESS_FAULT_EN
  // The response code has no consumer when access faults are disabled.
  logic        rresp_unused_s;
  assign rresp_unused_s = ^IFU_rresp;
`endif

  // Next-state, discard tracking and transfer strobes.
  always_comb begin
    state_s   = state_r;
    discard_s = discard_r;
    launch_s  = 1'b0;
    take_s    = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pc_change && !BRANCH_flushIF) begin
          launch_s = 1'b1;
          state_s  = ADDR;
        end else begin
          state_s  = IDLE;
        end
      end
      ADDR: begin
        // The address stays presented until accepted even when flushed.
        if (BRANCH_flushIF) begin
          discard_s = 1'b1;
        end else begin
          discard_s = discard_r;
        end
        if (IFU_arready) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (IFU_rvalid) begin
          if (discard_r || BRANCH_flushIF) begin
            state_s   = IDLE;
            discard_s = 1'b0;
          end else begin
            take_s    = 1'b1;
            state_s   = HOLD;
          end
        end else if (BRANCH_flushIF) begin
          discard_s = 1'b1;
        end else begin
          discard_s = discard_r;
        end
      end
      HOLD: begin
        // Flush wins over a downstream stall.
        if (BRANCH_flushIF || !FORWARD_stallID) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = HOLD;
        end
      end
      default: begin
        state_s   = IDLE;
        discard_s = 1'b0;
      end
    endcase
  end

  // Combinational stall request toward the hazard unit.
  always_comb begin
    busy_s = launch_s
           | (state_r == ADDR)
           | (state_r == DATA)
           | ((state_r == HOLD) && FORWARD_stallID && !BRANCH_flushIF);
  end

  // State and discard flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      discard_r <= discard_s;
    end
  end

  // Registered handshake and instruction outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      req_pc_r  <= 32'h0000_0000;
      inst_r    <= NOP_INST;
      inst_pc_r <= 32'h0000_0000;
      valid_r   <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      arvalid_r <= (state_s == ADDR);
      rready_r  <= (state_s == DATA);
      if (launch_s) begin
        req_pc_r <= IFU_o_pc;
      end
      if (take_s) begin
        valid_r   <= 1'b1;
        inst_pc_r <= req_pc_r;
`ifdef IFU_ACCESS_FAULT_EN
        if (IFU_rresp != 2'b00) begin
          inst_r  <= NOP_INST;
          fault_r <= 1'b1;
        end else begin
          inst_r  <= IFU_rdata;
          fault_r <= 1'b0;
        end
`else
        inst_r    <= IFU_rdata;
        fault_r   <= 1'b0;
`endif
      end else if (release_s) begin
        valid_r <= 1'b0;
        fault_r <= 1'b0;
      end
    end
  end

  assign IFU_arvalid   = arvalid_r;
  assign IFU_rready    = rready_r;
  assign IFU_araddr    = req_pc_r;
  assign IFU_o_inst    = inst_r;
  assign IFU_o_inst_pc = inst_pc_r;
  assign IFU_o_valid   = valid_r;
  assign IFU_o_fault   = fault_r;
  assign IFU_o_busy    = busy_s;

endmodule
